sc_dmem_responder: RTL and testbench



---
 rtl/sc_dmem_pkg.sv | 17 +
 rtl/sc_dmem_ram.sv | 31 +++
 rtl/sc_dmem_responder.sv | 176 +++++++++++++++++
 tb/tb_sc_dmem_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sc_dmem_pkg.sv
// rtl/sc_dmem_pkg.sv - shared state encodings and constants for the data-memory responder
package sc_dmem_pkg;

  // Responder FSM state encodings
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Largest number of wait states the 4-bit wait counter can express
  localparam int unsigned MAX_WAIT_CYCLES = 15;

  // Word address of the cycle counter: the top of the address space
  function automatic int unsigned ctr_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/sc_dmem_ram.sv
// rtl/sc_dmem_ram.sv - byte-enable synchronous RAM with one registered read/write port
module sc_dmem_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Single port: byte-masked write, or registered read that holds until the next read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sc_dmem_responder.sv
// rtl/sc_dmem_responder.sv - wait-state data-memory responder; SC_DMEM_CYCLE_COUNTER_EN maps the top address to a cycle counter
module sc_dmem_responder
  import sc_dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_RESP = S_RESP
  } state_t;

  localparam int RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WAIT_EFF = (WAIT_CYCLES > int'(MAX_WAIT_CYCLES)) ? int'(MAX_WAIT_CYCLES) : WAIT_CYCLES;
  localparam logic [3:0]        WAIT_INIT = (WAIT_EFF > 0) ? 4'(WAIT_EFF - 1) : 4'd0;
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CTR_ADDR  = ADDR_W'(ctr_addr(ADDR_W));

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W/8-1:0] lat_be;
  logic                sel_ram;
  logic                sel_ctr;

  logic                accept;
  logic                go_resp;
  logic                cur_we;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic [DATA_W/8-1:0] cur_be;
  logic                in_range;
  logic                is_ctr;
  logic                ram_en;
  logic [DATA_W-1:0]   ram_rdata;

  // With zero wait states the access happens on the accept edge, so use the live request
  always_comb begin
    accept    = req_valid && req_ready;
    cur_we    = (state == ST_IDLE) ? req_we    : lat_we;
    cur_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    cur_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
    cur_be    = (state == ST_IDLE) ? req_be    : lat_be;
    go_resp   = ((state == ST_IDLE) && accept && (WAIT_EFF == 0)) ||
                ((state == ST_WAIT) && (wait_cnt == 4'd0));
    in_range  = {1'b0, cur_addr} < DEPTH_L;
`ifdef SC_DMEM_CYCLE_COUNTER_EN
    is_ctr    = (cur_addr == CTR_ADDR);
`else
    is_ctr    = 1'b0;
`endif
    // Reset wins over a pending access so a dropped write never lands
    ram_en    = go_resp && in_range && !is_ctr && rst_n;
  end

  sc_dmem_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur_we),
    .be    (cur_be),
    .addr  (cur_addr[RAM_AW-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Request/response handshake FSM with registered channel outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      sel_ram   <= 1'b0;
      sel_ctr   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            req_ready <= 1'b0;
            if (WAIT_EFF == 0) begin
              state <= ST_RESP;
            end else begin
              wait_cnt <= WAIT_INIT;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            sel_ram   <= 1'b0;
            sel_ctr   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Response contents are fixed on the edge that enters RESP and held there
      if (go_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= !in_range && !is_ctr;
        sel_ram   <= !cur_we && in_range && !is_ctr;
        sel_ctr   <= !cur_we && is_ctr;
      end
    end
  end

`ifdef SC_DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  logic [31:0] ctr_snap;

  // Free-running cycle counter, snapshotted when a response is formed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      ctr_snap  <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (go_resp) ctr_snap <= cycle_cnt;
    end
  end

  // Read data source: RAM word, counter snapshot, or zero for writes and errors
  always_comb begin
    rsp_rdata = '0;
    if (sel_ram)      rsp_rdata = ram_rdata;
    else if (sel_ctr) rsp_rdata = DATA_W'(ctr_snap);
  end
`else
  // Read data source: RAM word, or zero for writes and errors
  always_comb begin
    rsp_rdata = '0;
    if (sel_ram) rsp_rdata = ram_rdata;
    if (sel_ctr) rsp_rdata = '0;
  end
`endif

endmodule

// File: tb/tb_sc_dmem_responder.sv
// tb/tb_sc_dmem_responder.sv - directed self-checking bench for sc_dmem_responder
module tb_sc_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_valid [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_err   [3];
  logic [31:0] rsp_rdata [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: one wait state; 1: zero wait states; 2: three wait states. All DEPTH=128.
  sc_dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  sc_dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  sc_dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance i; lat counts falling edges from the accept edge to rsp_valid
  task automatic xact(input int i, input logic we, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic err,
                      output int lat, output int acc_cyc);
    int n;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = d; req_be = be;
    req_valid[i] = 1'b1; rsp_ready[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid[i] = 1'b0;
    req_addr = 8'hXX; req_wdata = 32'hXXXXXXXX;
    lat = 1;
    while (!rsp_valid[i] && lat < 40) begin @(negedge clk); lat++; end
    rd  = rsp_rdata[i];
    err = rsp_err[i];
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, acc_a, acc_b;

  initial begin
    rst_n = 1'b0;
    req_we = 1'b0; req_addr = 8'h00; req_wdata = 32'h0; req_be = 4'h0;
    for (int k = 0; k < 3; k++) begin req_valid[k] = 1'b0; rsp_ready[k] = 1'b1; end
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err[0]},   32'd0);
    check("rst_rsp_rdata", rsp_rdata[0],          32'd0);
    rst_n = 1'b1;

    // Full write then read, one wait state
    xact(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, err, lat, acc_a);
    check("wr_lat",   lat, 32'd2);
    check("wr_rdata", rd,  32'd0);
    check("wr_err",   {31'd0, err}, 32'd0);
    xact(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("rd_lat",   lat, 32'd2);
    check("rd_data",  rd,  32'hDEADBEEF);

    // Byte-0-only write
    xact(0, 1'b1, 8'h10, 32'h00000055, 4'b0001, rd, err, lat, acc_a);
    xact(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("partial_rd", rd, 32'hDEADBE55);

    // Write with no byte enables leaves memory untouched
    xact(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, rd, err, lat, acc_a);
    check("be0_err", {31'd0, err}, 32'd0);
    xact(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("be0_rd", rd, 32'hDEADBE55);

    // Out-of-range read held under backpressure
    @(negedge clk);
    req_we = 1'b0; req_addr = 8'h90; req_be = 4'hF;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("bp_first_wait", {31'd0, rsp_valid[0]}, 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp_err",   {31'd0, rsp_err[0]},   32'd1);
      check("bp_rdata", rsp_rdata[0],          32'd0);
      check("bp_ready", {31'd0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_rel_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("bp_rel_ready", {31'd0, req_ready[0]}, 32'd1);
    check("bp_rel_err",   {31'd0, rsp_err[0]},   32'd0);

    // Out-of-range write must not alias onto 0x10
    xact(0, 1'b1, 8'h90, 32'hA5A5A5A5, 4'hF, rd, err, lat, acc_a);
    check("oor_wr_err", {31'd0, err}, 32'd1);
    check("oor_wr_lat", lat, 32'd2);
    xact(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("oor_no_alias", rd, 32'hDEADBE55);
    xact(0, 1'b0, 8'hFF, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("top_addr_err", {31'd0, err}, 32'd1);

    // Zero wait states: back-to-back transactions, one accept every two cycles
    xact(1, 1'b1, 8'h00, 32'h11111111, 4'hF, rd, err, lat, acc_a);
    check("w0_wr_lat", lat, 32'd1);
    xact(1, 1'b1, 8'h01, 32'h22222222, 4'hF, rd, err, lat, acc_a);
    xact(1, 1'b0, 8'h00, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("w0_rd0_lat",  lat, 32'd1);
    check("w0_rd0_data", rd,  32'h11111111);
    xact(1, 1'b0, 8'h01, 32'h0, 4'h0, rd, err, lat, acc_b);
    check("w0_rd1_lat",  lat, 32'd1);
    check("w0_rd1_data", rd,  32'h22222222);
    check("w0_spacing",  acc_b - acc_a, 32'd2);

    // Reset during the first wait cycle drops a pending write
    xact(2, 1'b1, 8'h20, 32'hCAFEF00D, 4'hF, rd, err, lat, acc_a);
    check("w3_wr_lat", lat, 32'd4);
    @(negedge clk);
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    check("mid_busy", {31'd0, req_ready[2]}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'd0, req_ready[2]}, 32'd1);
    check("mid_rst_valid", {31'd0, rsp_valid[2]}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_no_rsp", {31'd0, rsp_valid[2]}, 32'd0);
    xact(2, 1'b0, 8'h20, 32'h0, 4'h0, rd, err, lat, acc_a);
    check("mid_rd_lat",  lat, 32'd4);
    check("mid_rd_data", rd,  32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
